// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Control bundles encode which registers freeze and which stages take a NOP.
package pipeline_ctrl_pkg;

    localparam int unsigned NREGS_DEFAULT = 8;
    localparam int unsigned RW_DEFAULT    = 3;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } ctrlState_e;

    // A bubble loads a NOP into the named pipeline register; a hold freezes it.
    typedef struct packed {
        logic pcHold;
        logic hold1;
        logic hold2;
        logic bubble2;
        logic bubble3;
        logic bubble4;
    } pipeCtl_t;

    localparam pipeCtl_t CTL_NONE = '0;

    localparam pipeCtl_t CTL_WB_REDIRECT = '{
        pcHold: 1'b0, hold1: 1'b0, hold2: 1'b0,
        bubble2: 1'b1, bubble3: 1'b1, bubble4: 1'b1
    };

    localparam pipeCtl_t CTL_EX_REDIRECT = '{
        pcHold: 1'b0, hold1: 1'b0, hold2: 1'b0,
        bubble2: 1'b1, bubble3: 1'b1, bubble4: 1'b0
    };

    localparam pipeCtl_t CTL_LOAD_USE = '{
        pcHold: 1'b1, hold1: 1'b1, hold2: 1'b1,
        bubble2: 1'b0, bubble3: 1'b1, bubble4: 1'b0
    };

    localparam pipeCtl_t CTL_MULTI_HOLD = '{
        pcHold: 1'b1, hold1: 1'b1, hold2: 1'b1,
        bubble2: 1'b0, bubble3: 1'b0, bubble4: 1'b0
    };

    // Empty LM/SM list: the instruction leaves RR as a NOP.
    localparam pipeCtl_t CTL_NOP_RETIRE = '{
        pcHold: 1'b0, hold1: 1'b0, hold2: 1'b0,
        bubble2: 1'b0, bubble3: 1'b1, bubble4: 1'b0
    };

endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit, plus any-set and exactly-one-set flags.
module lowest_set_bit #(
    parameter int unsigned Width = 8,
    parameter int unsigned IdxW  = 3
) (
    input  logic [Width-1:0] vec,
    output logic [IdxW-1:0]  index,
    output logic             found,
    output logic             single
);

    // Scan downward so the lowest set bit is the final assignment.
    always_comb begin
        index = '0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IdxW'(i);
            end
        end
    end

    assign found  = |vec;
    assign single = found && ((vec & (vec - Width'(1))) == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: resolves redirects and load-use hazards, and
// issues LM/SM instructions out of RR as one register micro-op per cycle.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned RW    = RW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rr_valid,
    input  logic [RW-1:0]    rr_src_a,
    input  logic [RW-1:0]    rr_src_b,
    input  logic             rr_use_a,
    input  logic             rr_use_b,
    input  logic             rr_multi,
    input  logic [NREGS-1:0] rr_reg_list,
    input  logic             ex_valid,
    input  logic             ex_load,
    input  logic [RW-1:0]    ex_dest,
    input  logic             ex_redirect,
    input  logic             wb_redirect,
    output logic             pc_hold,
    output logic             hold1,
    output logic             hold2,
    output logic             bubble2,
    output logic             bubble3,
    output logic             bubble4,
    output logic             multi_active,
    output logic [RW-1:0]    multi_reg,
    output logic [RW:0]      multi_offset,
    output logic             multi_last
);

    ctrlState_e       stateQ, stateD;
    logic [NREGS-1:0] remainQ, remainD;
    logic [RW:0]      countQ, countD;

    logic [NREGS-1:0] lsbVec;
    logic [RW-1:0]    lsbIdx;
    logic             lsbFound;
    logic             lsbSingle;
    logic [NREGS-1:0] issueMask;
    logic             loadUse;

    pipeCtl_t    ctl;
    logic        mActive;
    logic [RW-1:0] mReg;
    logic [RW:0] mOffset;
    logic        mLast;

    // Once sequencing has started, the latched remainder replaces the live list.
    assign lsbVec = (stateQ == MULTI) ? remainQ : rr_reg_list;

    lowest_set_bit #(
        .Width (NREGS),
        .IdxW  (RW)
    ) uLsb (
        .vec    (lsbVec),
        .index  (lsbIdx),
        .found  (lsbFound),
        .single (lsbSingle)
    );

    assign issueMask = NREGS'(1) << lsbIdx;

    assign loadUse = ex_valid && ex_load && rr_valid &&
                     ((rr_use_a && (rr_src_a == ex_dest)) ||
                      (rr_use_b && (rr_src_b == ex_dest)));

    always_comb begin
        ctl     = CTL_NONE;
        mActive = 1'b0;
        mReg    = '0;
        mOffset = '0;
        mLast   = 1'b0;
        stateD  = stateQ;
        remainD = remainQ;
        countD  = countQ;

        if (wb_redirect) begin
            ctl     = CTL_WB_REDIRECT;
            stateD  = RUN;
            remainD = '0;
            countD  = '0;
        end else if (ex_redirect) begin
            ctl     = CTL_EX_REDIRECT;
            stateD  = RUN;
            remainD = '0;
            countD  = '0;
        end else if (loadUse) begin
            ctl = CTL_LOAD_USE;
        end else if (stateQ == MULTI) begin
            if (lsbFound) begin
                mActive = 1'b1;
                mReg    = lsbIdx;
                mOffset = countQ;
                if (lsbSingle) begin
                    mLast   = 1'b1;
                    stateD  = RUN;
                    remainD = '0;
                    countD  = '0;
                end else begin
                    ctl     = CTL_MULTI_HOLD;
                    remainD = remainQ & ~issueMask;
                    countD  = countQ + (RW+1)'(1);
                end
            end else begin
                // Unreachable with a consistent remainder; recover to RUN.
                stateD  = RUN;
                remainD = '0;
                countD  = '0;
            end
        end else if (rr_valid && rr_multi) begin
            if (lsbFound) begin
                mActive = 1'b1;
                mReg    = lsbIdx;
                if (lsbSingle) begin
                    mLast = 1'b1;
                end else begin
                    ctl     = CTL_MULTI_HOLD;
                    remainD = rr_reg_list & ~issueMask;
                    countD  = (RW+1)'(1);
                    stateD  = MULTI;
                end
            end else begin
                ctl = CTL_NOP_RETIRE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ  <= RUN;
            remainQ <= '0;
            countQ  <= '0;
        end else begin
            stateQ  <= stateD;
            remainQ <= remainD;
            countQ  <= countD;
        end
    end

    // Outputs are Mealy, so force them quiet while reset is held.
    assign pc_hold      = reset & ctl.pcHold;
    assign hold1        = reset & ctl.hold1;
    assign hold2        = reset & ctl.hold2;
    assign bubble2      = reset & ctl.bubble2;
    assign bubble3      = reset & ctl.bubble3;
    assign bubble4      = reset & ctl.bubble4;
    assign multi_active = reset & mActive;
    assign multi_reg    = reset ? mReg : '0;
    assign multi_offset = reset ? mOffset : '0;
    assign multi_last   = reset & mLast;

endmodule
